// File: rtl/mem_stage.sv
// MIPS memory-access stage: issues loads/stores over a req/ack data port, steers byte
// lanes, extends load data and registers the result into the writeback pipeline registers.
module mem_stage #(
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] aluResult1_PR,
    input  logic [31:0] readDataB1_PR,
    input  logic [31:0] Instr1_PR,
    input  logic [4:0]  writeRegister1_PR,
    input  logic        do_writeback1_PR,
    input  logic        MemRead1_PR,
    input  logic        MemWrite1_PR,
    input  logic        MemtoReg1_PR,
    output logic [31:0] Data1_MEM,
    output logic [4:0]  writeRegister1_MEM,
    output logic        do_writeback1_MEM,
    output logic        STALL,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Data1_WB,
    output logic [4:0]  writeRegister1_WB,
    output logic        do_writeback1_WB,
    output logic        exc_align,
    output logic        exc_bus
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] data_wb_q, data_wb_d;
    logic [4:0]  wr_wb_q, wr_wb_d;
    logic        wb_wb_q, wb_wb_d;
    logic        exc_align_q, exc_align_d, exc_bus_q, exc_bus_d;

    // Access context captured at issue so the completion does not depend on upstream holding.
    size_t       size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  blane_q, blane_d;
    logic        hlane_q, hlane_d;
    logic        store_q, store_d, m2r_q, m2r_d, wb_l_q, wb_l_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  wr_l_q, wr_l_d;

    logic [5:0]  opcode;
    size_t       size_dec;
    logic        sign_dec, memop, misaligned;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic        unused_instr;

    assign unused_instr       = ^Instr1_PR[25:0];
    assign Data1_MEM          = aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;

    always_comb begin
        opcode   = Instr1_PR[31:26];
        size_dec = SZ_WORD;
        sign_dec = 1'b0;
        case (opcode)
            6'h20: begin size_dec = SZ_BYTE; sign_dec = 1'b1; end
            6'h24, 6'h28: size_dec = SZ_BYTE;
            6'h21: begin size_dec = SZ_HALF; sign_dec = 1'b1; end
            6'h25, 6'h29: size_dec = SZ_HALF;
            default: size_dec = SZ_WORD;
        endcase
        memop      = MemRead1_PR | MemWrite1_PR;
        misaligned = ((size_dec == SZ_HALF) && aluResult1_PR[0]) ||
                     ((size_dec == SZ_WORD) && (aluResult1_PR[1:0] != 2'b00));
        byte_lane  = BIG_ENDIAN ? (2'd3 - aluResult1_PR[1:0]) : aluResult1_PR[1:0];
        half_lane  = aluResult1_PR[1] ^ BIG_ENDIAN;
        case (size_dec)
            SZ_BYTE: begin
                be_dec    = 4'b0001 << byte_lane;
                wdata_dec = {4{readDataB1_PR[7:0]}};
            end
            SZ_HALF: begin
                be_dec    = half_lane ? 4'b1100 : 4'b0011;
                wdata_dec = {2{readDataB1_PR[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = readDataB1_PR;
            end
        endcase
    end

    always_comb begin
        load_byte = dmem_rdata[{blane_q, 3'b000} +: 8];
        load_half = hlane_q ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sign_q & load_byte[7]}}, load_byte};
            SZ_HALF: load_val = {{16{sign_q & load_half[15]}}, load_half};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        data_wb_d   = data_wb_q;
        wr_wb_d     = wr_wb_q;
        wb_wb_d     = wb_wb_q;
        exc_align_d = 1'b0;
        exc_bus_d   = 1'b0;
        size_d      = size_q;
        sign_d      = sign_q;
        blane_d     = blane_q;
        hlane_d     = hlane_q;
        store_d     = store_q;
        m2r_d       = m2r_q;
        wb_l_d      = wb_l_q;
        alu_d       = alu_q;
        wr_l_d      = wr_l_q;
        STALL       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!memop) begin
                    data_wb_d = aluResult1_PR;
                    wr_wb_d   = writeRegister1_PR;
                    wb_wb_d   = do_writeback1_PR;
                end else if (misaligned) begin
                    data_wb_d   = aluResult1_PR;
                    wr_wb_d     = writeRegister1_PR;
                    wb_wb_d     = 1'b0;
                    exc_align_d = 1'b1;
                end else begin
                    STALL   = 1'b1;
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = MemWrite1_PR;
                    addr_d  = {aluResult1_PR[31:2], 2'b00};
                    be_d    = be_dec;
                    wdata_d = wdata_dec;
                    wb_wb_d = 1'b0;
                    size_d  = size_dec;
                    sign_d  = sign_dec;
                    blane_d = byte_lane;
                    hlane_d = half_lane;
                    store_d = MemWrite1_PR;
                    m2r_d   = MemtoReg1_PR;
                    wb_l_d  = do_writeback1_PR;
                    alu_d   = aluResult1_PR;
                    wr_l_d  = writeRegister1_PR;
                end
            end
            default: begin
                if (dmem_ack) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    wr_wb_d   = wr_l_q;
                    data_wb_d = (!store_q && m2r_q) ? load_val : alu_q;
                    wb_wb_d   = store_q ? 1'b0 : wb_l_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    wb_wb_d   = 1'b0;
                    exc_bus_d = 1'b1;
                end else begin
                    STALL = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            data_wb_q   <= '0;
            wr_wb_q     <= '0;
            wb_wb_q     <= 1'b0;
            exc_align_q <= 1'b0;
            exc_bus_q   <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
            blane_q     <= '0;
            hlane_q     <= 1'b0;
            store_q     <= 1'b0;
            m2r_q       <= 1'b0;
            wb_l_q      <= 1'b0;
            alu_q       <= '0;
            wr_l_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            data_wb_q   <= data_wb_d;
            wr_wb_q     <= wr_wb_d;
            wb_wb_q     <= wb_wb_d;
            exc_align_q <= exc_align_d;
            exc_bus_q   <= exc_bus_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            blane_q     <= blane_d;
            hlane_q     <= hlane_d;
            store_q     <= store_d;
            m2r_q       <= m2r_d;
            wb_l_q      <= wb_l_d;
            alu_q       <= alu_d;
            wr_l_q      <= wr_l_d;
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_be           = be_q;
    assign dmem_wdata        = wdata_q;
    assign Data1_WB          = data_wb_q;
    assign writeRegister1_WB = wr_wb_q;
    assign do_writeback1_WB  = wb_wb_q;
    assign exc_align         = exc_align_q;
    assign exc_bus           = exc_bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked against a byte-level memory model.
module tb_mem_stage;

    localparam bit BE      = 1'b0;
    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] aluResult1_PR, readDataB1_PR, Instr1_PR;
    logic [4:0]  writeRegister1_PR;
    logic        do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR;
    logic [31:0] Data1_MEM;
    logic [4:0]  writeRegister1_MEM;
    logic        do_writeback1_MEM, STALL;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] Data1_WB;
    logic [4:0]  writeRegister1_WB;
    logic        do_writeback1_WB, exc_align, exc_bus;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT(TIMEOUT), .BIG_ENDIAN(BE)) dut (
        .CLK(CLK), .RESET(RESET),
        .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR), .Instr1_PR(Instr1_PR),
        .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
        .MemRead1_PR(MemRead1_PR), .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR),
        .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
        .do_writeback1_MEM(do_writeback1_MEM), .STALL(STALL),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB),
        .do_writeback1_WB(do_writeback1_WB), .exc_align(exc_align), .exc_bus(exc_bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return op inside {6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic int size_of(input logic [5:0] op);
        if (op inside {6'h20, 6'h24, 6'h28}) return 1;
        if (op inside {6'h21, 6'h25, 6'h29}) return 2;
        return 4;
    endfunction

    // Physical lane carrying byte k (address offset within the word).
    function automatic int lane(input int k);
        return BE ? 3 - k : k;
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [31:0] addr);
        logic [3:0] be = 4'b0000;
        for (int j = 0; j < size_of(op); j++) be[lane(int'(addr[1:0]) + j)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] d);
        case (size_of(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v = 32'h0;
        logic [7:0]  b;
        for (int j = 0; j < size_of(op); j++) begin
            b = 8'(rdata >> (8 * lane(int'(addr[1:0]) + j)));
            if (BE) v = (v << 8) | 32'(b);
            else    v = v | (32'(b) << (8 * j));
        end
        if (op == 6'h20 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 6'h21 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic set_inputs(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] wr, input logic wb, input logic m2r);
        Instr1_PR         = {op, 26'($urandom)};
        aluResult1_PR     = addr;
        readDataB1_PR     = sdata;
        writeRegister1_PR = wr;
        do_writeback1_PR  = wb;
        MemRead1_PR       = is_load(op);
        MemWrite1_PR      = is_store(op);
        MemtoReg1_PR      = m2r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wr, input logic wb, input logic m2r,
                          input int delay, input logic [31:0] rdata);
        bit ld, st;
        int sz, stalls;
        ld = is_load(op);
        st = is_store(op);
        sz = size_of(op);
        set_inputs(op, addr, sdata, wr, wb, m2r);
        dmem_ack = 1'b0;
        #1;
        check("fwd_data", Data1_MEM, addr);
        check("fwd_reg", 32'(writeRegister1_MEM), 32'(wr));
        check("fwd_wb", 32'(do_writeback1_MEM), 32'(wb & ~ld));
        if (!ld && !st) begin
            check("pass_stall", 32'(STALL), 32'd0);
            tick();
            check("pass_data", Data1_WB, addr);
            check("pass_reg", 32'(writeRegister1_WB), 32'(wr));
            check("pass_wb", 32'(do_writeback1_WB), 32'(wb));
            check("pass_req", 32'(dmem_req), 32'd0);
        end else if ((int'(addr[1:0]) % sz) != 0) begin
            check("mis_stall", 32'(STALL), 32'd0);
            tick();
            check("mis_exc", 32'(exc_align), 32'd1);
            check("mis_wb", 32'(do_writeback1_WB), 32'd0);
            check("mis_req", 32'(dmem_req), 32'd0);
            set_inputs(6'h00, addr, sdata, wr, 1'b0, 1'b0);
            tick();
            check("mis_pulse", 32'(exc_align), 32'd0);
        end else begin
            stalls = STALL ? 1 : 0;
            tick();
            check("req_on", 32'(dmem_req), 32'd1);
            check("req_we", 32'(dmem_we), 32'(st));
            check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("req_be", 32'(dmem_be), 32'(exp_be(op, addr)));
            if (st) check("req_wdata", dmem_wdata, exp_wdata(op, sdata));
            for (int i = 0; i < delay; i++) begin
                if (STALL) stalls++;
                check("req_hold", 32'(dmem_req), 32'd1);
                check("addr_hold", dmem_addr, addr & 32'hFFFF_FFFC);
                tick();
            end
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            #1;
            check("ack_stall", 32'(STALL), 32'd0);
            check("stall_cycles", 32'(stalls), 32'(delay + 1));
            tick();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'h0;
            check("done_req", 32'(dmem_req), 32'd0);
            if (st) begin
                check("st_wb", 32'(do_writeback1_WB), 32'd0);
            end else begin
                check("ld_wb", 32'(do_writeback1_WB), 32'(wb));
                check("ld_reg", 32'(writeRegister1_WB), 32'(wr));
                check("ld_data", Data1_WB, m2r ? exp_load(op, addr, rdata) : addr);
            end
        end
        $display("txn op=%h addr=%h sdata=%h rdata=%h delay=%0d wb_data=%h", op, addr, sdata,
                 rdata, delay, Data1_WB);
    endtask

    logic [5:0] op_tab [9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00};

    initial begin
        logic [5:0]  op;
        logic [31:0] addr;
        int          sz;
        RESET = 1'b1;
        set_inputs(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        tick();
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_data", Data1_WB, 32'h0);
        check("rst_reg", 32'(writeRegister1_WB), 32'd0);
        check("rst_wb", 32'(do_writeback1_WB), 32'd0);
        check("rst_align", 32'(exc_align), 32'd0);
        check("rst_bus", 32'(exc_bus), 32'd0);
        RESET = 1'b0;

        run_op(6'h00, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h0);
        run_op(6'h20, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'h80FF_0011);
        check("lb_value", Data1_WB, 32'hFFFF_FF80);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_be", 32'(dmem_be), 32'b1000);
        run_op(6'h24, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'h80FF_0011);
        check("lbu_value", Data1_WB, 32'h0000_0080);
        run_op(6'h29, 32'h202, 32'hABCD_1234, 5'd3, 1'b0, 1'b0, 0, 32'h0);
        check("sh_be", 32'(dmem_be), 32'b1100);
        check("sh_wdata", dmem_wdata, 32'h1234_1234);
        check("sh_we", 32'(dmem_we), 32'd1);
        run_op(6'h23, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        check("lw_value", Data1_WB, 32'hDEAD_BEEF);
        run_op(6'h23, 32'h301, 32'h0, 5'd9, 1'b1, 1'b1, 0, 32'h0);

        // Bus timeout: no ack ever arrives.
        set_inputs(6'h23, 32'h400, 32'h0, 5'd4, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_req", 32'(dmem_req), 32'd1);
            check("to_stall", 32'(STALL), (i == TIMEOUT - 1) ? 32'd0 : 32'd1);
            check("to_early", 32'(exc_bus), 32'd0);
            tick();
        end
        check("to_exc", 32'(exc_bus), 32'd1);
        check("to_req_off", 32'(dmem_req), 32'd0);
        check("to_wb", 32'(do_writeback1_WB), 32'd0);
        set_inputs(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        check("to_pulse", 32'(exc_bus), 32'd0);
        $display("txn timeout addr=00000400 wait_cycles=%0d", TIMEOUT);

        // Reset while an access is outstanding; a late ack must be ignored.
        set_inputs(6'h23, 32'h500, 32'h0, 5'd6, 1'b1, 1'b1);
        tick();
        check("abort_req_on", 32'(dmem_req), 32'd1);
        RESET = 1'b1;
        tick();
        check("abort_req", 32'(dmem_req), 32'd0);
        RESET = 1'b0;
        set_inputs(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_data", Data1_WB, 32'h0);
        check("late_ack_bus", 32'(exc_bus), 32'd0);
        $display("txn reset_abort addr=00000500");

        for (int n = 0; n < 40; n++) begin
            op   = op_tab[$urandom_range(0, 8)];
            addr = $urandom;
            sz   = size_of(op);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'(int'(addr[1:0]) - (int'(addr[1:0]) % sz));
            run_op(op, addr, $urandom, 5'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                   $urandom_range(0, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the MIPS integer pipeline, directly downstream of the execute stage. Consumes the execute pipeline registers and performs loads and stores over a req/ack data-memory port, including byte-lane steering and sign/zero extension. Stalls upstream while an access is outstanding, then registers the result into the writeback pipeline registers. Also provides the MEM-stage forwarding values.

Parameters:
TIMEOUT, 16, WAIT cycles without dmem_ack before bus error (>=2)
BIG_ENDIAN, 0, 0: byte k of a word on rdata/wdata[8k+7:8k]; 1: on lane 3-k

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous active-high reset
aluResult1_PR  in  32  effective address (mem op) or ALU result
readDataB1_PR  in  32  store data
Instr1_PR  in  32  instruction; [31:26] selects access size/sign
writeRegister1_PR  in  5  destination register
do_writeback1_PR  in  1  instruction writes a register
MemRead1_PR  in  1  load
MemWrite1_PR  in  1  store
MemtoReg1_PR  in  1  result comes from memory
Data1_MEM  out  32  forwarding value = aluResult1_PR (comb.)
writeRegister1_MEM  out  5  = writeRegister1_PR (comb.)
do_writeback1_MEM  out  1  = do_writeback1_PR & ~MemRead1_PR (comb.; loads not forwardable here)
STALL  out  1  hold upstream pipeline registers (comb.)
dmem_req  out  1  access request, registered
dmem_we  out  1  1 = store
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete; dmem_rdata valid this cycle
dmem_rdata  in  32  read word
Data1_WB  out  32  registered result to writeback
writeRegister1_WB  out  5  registered destination
do_writeback1_WB  out  1  registered write enable
exc_align  out  1  one-cycle pulse, misaligned access
exc_bus  out  1  one-cycle pulse, access timeout

Behaviour:
- Reset: state IDLE, timeout counter 0, all outputs of registered type 0 (dmem_req/we/addr/be/wdata, Data1_WB, writeRegister1_WB, do_writeback1_WB, exc_align, exc_bus). RESET mid-access aborts: dmem_req low after that edge, late ack ignored.
- memop = MemRead1_PR | MemWrite1_PR. Size from opcode: LB 0x20, LBU 0x24, SB 0x28 byte; LH 0x21, LHU 0x25, SH 0x29 half; LW 0x23, SW 0x2B word. Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
- IDLE, no memop: one cycle pass-through; WB regs <= {aluResult1_PR, writeRegister1_PR, do_writeback1_PR}; STALL=0.
- IDLE, misaligned memop: no request; STALL=0; exc_align=1 next cycle; do_writeback1_WB<=0.
- IDLE, aligned memop: STALL=1; next edge -> WAIT with dmem_req=1 and dmem_we/addr/be/wdata latched.
- WAIT: request fields held stable. STALL = ~dmem_ack. On ack: WB regs load (load: extended data if MemtoReg1_PR else aluResult1_PR; store: do_writeback1_WB=0), dmem_req<=0, -> IDLE. Upstream advances on that same edge.
- WAIT timeout: counter increments each WAIT cycle without ack; when it reaches TIMEOUT-1 without ack -> IDLE, exc_bus pulse, do_writeback1_WB<=0, STALL=0 that cycle. Ack on the final cycle wins over timeout.
- Byte lane n=addr[1:0] (half: addr[1]); lane index mapped through BIG_ENDIAN. Store: SB be=one-hot lane, wdata=byte x4; SH be=0011/1100, wdata=half x2; SW be=1111.
- Load: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- Minimum memop latency 2 cycles (IDLE + 1 WAIT with ack).

Test Plan:
- Non-mem op aluResult1_PR=0x1234, wr=5, wb=1 -> next cycle Data1_WB=0x1234, writeRegister1_WB=5, STALL never high.
- LB addr 0x103, rdata 0x80FF_0011, BIG_ENDIAN=0 -> dmem_addr 0x100, be 1000, Data1_WB=0xFFFFFF80; LBU -> 0x00000080.
- SH addr 0x202, data 0xABCD_1234 -> be 1100, wdata 0x12341234, dmem_we=1, do_writeback1_WB=0.
- LW with ack delayed 3 cycles -> STALL high 4 cycles, req/addr stable throughout, Data1_WB=rdata one edge after ack.
- LW addr 0x301 -> exc_align pulse, dmem_req never asserted, do_writeback1_WB=0.
- No ack, TIMEOUT=16 -> exc_bus after 16 WAIT cycles, back to IDLE; RESET asserted in WAIT -> dmem_req=0 next cycle.
